// File: rtl/fpu_cvt_retire.sv
// Retire stage behind the float/int convert unit: derives IEEE exception flags per result,
// queues results in an in-order FIFO toward writeback and keeps the sticky fflags register.
package pkg_opengpu;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      FPU_ADD   = 4'd0,
      FPU_SUB   = 4'd1,
      FPU_MUL   = 4'd2,
      FPU_CVTWS = 4'd3,
      FPU_CVTSW = 4'd4,
      FPU_NOP   = 4'd15
   } fpu_op_t;
endpackage

module fpu_cvt_retire
   import pkg_opengpu::*;
#(
   parameter int DEPTH     = 2,
   parameter int TAG_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  fpu_op_t                    in_op,
   input  logic [DATA_WIDTH-1:0]      in_operand,
   input  logic [DATA_WIDTH-1:0]      in_result,
   input  logic [TAG_WIDTH-1:0]       in_rd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [TAG_WIDTH-1:0]       out_rd,
   output logic [4:0]                 out_flags,
   output logic [4:0]                 fflags,
   input  logic                       fflags_clr,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
   localparam logic [4:0] FLAG_NV = 5'b10000;
   localparam logic [4:0] FLAG_NX = 5'b00001;

   // float -> signed int: invalid on NaN/Inf/out-of-range, inexact on a dropped fraction
   function automatic logic [4:0] cvtws_flags(input logic [31:0] op);
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic [23:0] mask;
      logic [4:0]  f;
      s    = op[31];
      e    = op[30:23];
      m    = op[22:0];
      mask = 24'h0;
      f    = 5'b00000;
      if (e == 8'd255) begin
         f = FLAG_NV;
      end else if (e >= 8'd158) begin
         if (s && (e == 8'd158) && (m == 23'h0)) f = 5'b00000;
         else                                    f = FLAG_NV;
      end else if (e < 8'd127) begin
         if (op[30:0] != 31'h0) f = FLAG_NX;
         else                   f = 5'b00000;
      end else if (e < 8'd150) begin
         mask = (24'h1 << (8'd150 - e)) - 24'h1;
         if ((m & mask[22:0]) != 23'h0) f = FLAG_NX;
         else                           f = 5'b00000;
      end else begin
         f = 5'b00000;
      end
      return f;
   endfunction

   // signed int -> float: inexact when bits below the 24-bit significand window are set
   function automatic logic [4:0] cvtsw_flags(input logic [31:0] op);
      logic [31:0] a;
      logic [31:0] mask;
      logic [4:0]  p;
      logic [4:0]  f;
      a    = op[31] ? (~op + 32'h1) : op;
      p    = 5'd0;
      mask = 32'h0;
      f    = 5'b00000;
      for (int i = 0; i < 32; i++) begin
         if (a[i]) p = 5'(i);
      end
      if (p > 5'd23) begin
         mask = (32'h1 << (p - 5'd23)) - 32'h1;
         if ((a & mask) != 32'h0) f = FLAG_NX;
         else                     f = 5'b00000;
      end else begin
         f = 5'b00000;
      end
      return f;
   endfunction

   logic [DATA_WIDTH-1:0] data_r  [DEPTH];
   logic [TAG_WIDTH-1:0]  rd_r    [DEPTH];
   logic [4:0]            flags_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic [4:0]            fflags_r;
   logic [4:0]            in_flags_s;
   logic                  push_s;
   logic                  pop_s;

   // Flag derivation for the incoming result
   always_comb begin
      in_flags_s = 5'b00000;
      case (in_op)
         FPU_CVTWS: in_flags_s = cvtws_flags(in_operand);
         FPU_CVTSW: in_flags_s = cvtsw_flags(in_operand);
         default:   in_flags_s = 5'b00000;
      endcase
   end

   assign in_ready  = !rst && (count_r != FULL_CNT);
   assign out_valid = (count_r != {CNT_W{1'b0}});
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;
   assign out_data  = data_r[rd_ptr_r];
   assign out_rd    = rd_r[rd_ptr_r];
   assign out_flags = flags_r[rd_ptr_r];
   assign count     = count_r;
   assign fflags    = fflags_r;

   // Entry storage; cleared on reset so the head fields read as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i]  <= {DATA_WIDTH{1'b0}};
            rd_r[i]    <= {TAG_WIDTH{1'b0}};
            flags_r[i] <= 5'b00000;
         end
      end else if (push_s) begin
         data_r[wr_ptr_r]  <= in_result;
         rd_r[wr_ptr_r]    <= in_rd;
         flags_r[wr_ptr_r] <= in_flags_s;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky flags accumulate only on retire; a same-cycle clear keeps the retiring flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fflags_r <= 5'b00000;
      end else begin
         fflags_r <= (fflags_clr ? 5'b00000 : fflags_r) | (pop_s ? flags_r[rd_ptr_r] : 5'b00000);
      end
   end
endmodule

// File: tb/tb_fpu_cvt_retire.sv
// Scoreboard bench for fpu_cvt_retire: directed pushes queue expected results, a monitor checks retires.
module tb_fpu_cvt_retire;
   import pkg_opengpu::*;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic [4:0]  flags;
   } exp_t;

   typedef struct {
      fpu_op_t     op;
      logic [31:0] operand;
      logic [31:0] result;
      logic [4:0]  rd;
      logic [4:0]  flags;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   fpu_op_t     in_op;
   logic [31:0] in_operand;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [4:0]  out_flags;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic [1:0]  count;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t exp_q[$];

   fpu_cvt_retire #(.DEPTH(2), .TAG_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_operand(in_operand), .in_result(in_result), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_flags(out_flags), .fflags(fflags),
      .fflags_clr(fflags_clr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one transfer attempt and records the expected retire if it should be accepted
   task automatic push(input fpu_op_t op, input logic [31:0] operand, input logic [31:0] result,
                       input logic [4:0] rd, input logic [4:0] fl);
      in_valid   = 1'b1;
      in_op      = op;
      in_operand = operand;
      in_result  = result;
      in_rd      = rd;
      @(posedge clk);
      exp_q.push_back('{data: result, rd: rd, flags: fl});
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every retire is compared against the oldest expected entry
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_retire: got rd=%0d data=0x%08h expected no output", out_rd, out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("retire_data",  out_data,  e.data);
            chk("retire_rd",    {27'h0, out_rd},    {27'h0, e.rd});
            chk("retire_flags", {27'h0, out_flags}, {27'h0, e.flags});
         end
      end
   end

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{FPU_CVTWS, 32'h4F000000, 32'h7FFFFFFF, 5'd4,  5'h10};
      vecs[1]  = '{FPU_CVTWS, 32'hCF000000, 32'h80000000, 5'd5,  5'h00};
      vecs[2]  = '{FPU_CVTWS, 32'h7FC00000, 32'h7FFFFFFF, 5'd6,  5'h10};
      vecs[3]  = '{FPU_CVTWS, 32'h3F000000, 32'h00000000, 5'd7,  5'h01};
      vecs[4]  = '{FPU_CVTWS, 32'h40000000, 32'h00000002, 5'd8,  5'h00};
      vecs[5]  = '{FPU_CVTWS, 32'h4B000001, 32'h00800001, 5'd9,  5'h00};
      vecs[6]  = '{FPU_CVTWS, 32'h80000000, 32'h00000000, 5'd10, 5'h00};
      vecs[7]  = '{FPU_CVTSW, 32'h01000001, 32'h4B800000, 5'd11, 5'h01};
      vecs[8]  = '{FPU_CVTSW, 32'h01000000, 32'h4B800000, 5'd12, 5'h00};
      vecs[9]  = '{FPU_CVTSW, 32'h80000000, 32'hCF000000, 5'd13, 5'h00};
      vecs[10] = '{FPU_CVTSW, 32'h7FFFFFFF, 32'h4F000000, 5'd14, 5'h01};
      vecs[11] = '{FPU_ADD,   32'h7FC00000, 32'hDEADBEEF, 5'd15, 5'h00};

      rst = 1'b1; in_valid = 1'b0; in_op = FPU_NOP; in_operand = 32'h0;
      in_result = 32'h0; in_rd = 5'd0; out_ready = 1'b0; fflags_clr = 1'b0;
      cycles(2);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_count",     {30'h0, count},     32'h0);
      chk("rst_fflags",    {27'h0, fflags},    32'h0);
      chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
      chk("rst_out_data",  out_data,           32'h0);
      chk("rst_out_rd",    {27'h0, out_rd},    32'h0);
      chk("rst_out_flags", {27'h0, out_flags}, 32'h0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

      // CVTWS 1.5 -> 1, inexact; one-cycle latency with no bypass
      in_valid = 1'b1; in_op = FPU_CVTWS; in_operand = 32'h3FC00000; in_result = 32'h1; in_rd = 5'd3;
      #1;
      chk("no_bypass_out_valid", {31'h0, out_valid}, 32'h0);
      @(posedge clk);
      exp_q.push_back('{data: 32'h1, rd: 5'd3, flags: 5'h01});
      #1;
      in_valid = 1'b0;
      chk("lat_out_valid", {31'h0, out_valid}, 32'h1);
      chk("lat_out_data",  out_data,           32'h1);
      chk("lat_out_rd",    {27'h0, out_rd},    32'h3);
      chk("lat_out_flags", {27'h0, out_flags}, 32'h01);
      chk("fflags_not_at_push", {27'h0, fflags}, 32'h0);
      cycles(1);
      chk("hold_out_rd", {27'h0, out_rd}, 32'h3);
      out_ready = 1'b1;
      cycles(1);
      chk("fflags_after_pop", {27'h0, fflags}, 32'h01);

      // Back-to-back vector stream with writeback always ready
      foreach (vecs[i]) push(vecs[i].op, vecs[i].operand, vecs[i].result, vecs[i].rd, vecs[i].flags);
      cycles(3);
      chk("stream_drained",  exp_q.size(), 32'h0);
      chk("stream_fflags",   {27'h0, fflags}, 32'h11);

      // Backpressure with DEPTH=2
      out_ready = 1'b0; fflags_clr = 1'b1;
      cycles(1);
      fflags_clr = 1'b0;
      chk("clr_idle", {27'h0, fflags}, 32'h0);
      push(FPU_CVTWS, 32'h4F000000, 32'h7FFFFFFF, 5'd1, 5'h10);
      push(FPU_CVTWS, 32'h3FC00000, 32'h00000001, 5'd2, 5'h01);
      chk("full_count",    {30'h0, count},    32'h2);
      chk("full_in_ready", {31'h0, in_ready}, 32'h0);
      in_valid = 1'b1; in_op = FPU_ADD; in_operand = 32'h0; in_result = 32'h12345678; in_rd = 5'd7;
      cycles(1);
      in_valid = 1'b0;
      chk("ignored_count", {30'h0, count}, 32'h2);
      out_ready = 1'b1;
      cycles(1);
      chk("pop1_count",    {30'h0, count},    32'h1);
      chk("pop1_in_ready", {31'h0, in_ready}, 32'h1);
      chk("pop1_fflags",   {27'h0, fflags},   32'h10);
      fflags_clr = 1'b1;
      cycles(1);
      chk("clr_with_pop", {27'h0, fflags}, 32'h01);
      chk("pop2_count",   {30'h0, count},  32'h0);
      cycles(1);
      fflags_clr = 1'b0;
      chk("clr_alone", {27'h0, fflags}, 32'h0);

      // Reset in the middle of a queued stream
      push(FPU_CVTWS, 32'h4F000000, 32'h7FFFFFFF, 5'd20, 5'h10);
      cycles(1);
      chk("pre_rst_fflags", {27'h0, fflags}, 32'h10);
      out_ready = 1'b0;
      push(FPU_CVTSW, 32'h01000001, 32'h4B800000, 5'd21, 5'h01);
      push(FPU_CVTSW, 32'h00000005, 32'h40A00000, 5'd22, 5'h00);
      chk("pre_rst_count", {30'h0, count}, 32'h2);
      #3;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("mid_rst_count",     {30'h0, count},     32'h0);
      chk("mid_rst_fflags",    {27'h0, fflags},    32'h0);
      chk("mid_rst_in_ready",  {31'h0, in_ready},  32'h0);
      chk("mid_rst_out_data",  out_data,           32'h0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push(FPU_CVTWS, 32'h3F000000, 32'h00000000, 5'd9, 5'h01);
      chk("post_rst_out_valid", {31'h0, out_valid}, 32'h1);
      chk("post_rst_out_rd",    {27'h0, out_rd},    32'h9);
      chk("post_rst_count",     {30'h0, count},     32'h1);
      out_ready = 1'b1;
      cycles(3);
      chk("final_drained", exp_q.size(), 32'h0);
      chk("final_fflags",  {27'h0, fflags}, 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/fpu_cvt_retire.md
# fpu_cvt_retire

Result-retire stage that sits directly downstream of the combinational float/integer convert unit. Each cycle it can capture one converted result with its destination register tag. It derives IEEE-754 exception flags from the original operand and buffers the result in a small in-order FIFO toward the register-file writeback port. It also maintains the sticky accumulated `fflags` register, which is updated only when a result is retired.

## Interface

Parameters:
- `DEPTH`, default 2: FIFO entries; legal values are 2 or 4.
- `TAG_WIDTH`, default 5: width of the destination register tag.
- `DATA_WIDTH` comes from `pkg_opengpu` (32) and is not a parameter.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  stage can accept a result.
- `in_op`  in  `fpu_op_t`  operation that produced the result.
- `in_operand`  in  32  original source operand.
- `in_result`  in  32  convert-unit result.
- `in_rd`  in  `TAG_WIDTH`  destination tag.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  writeback accepts the head entry.
- `out_data`  out  32  head result.
- `out_rd`  out  `TAG_WIDTH`  head tag.
- `out_flags`  out  5  head flags: NV[4], DZ[3], OF[2], UF[1], NX[0].
- `fflags`  out  5  sticky accumulated flags.
- `fflags_clr`  in  1  clear the sticky flags.
- `count`  out  `$clog2(DEPTH)+1`  occupancy.

## Operation

- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`. Both are strictly in order.
- Flags are computed combinationally at push and stored with the entry. DZ, OF and UF are always 0.
- FPU_CVTWS, with the operand fields s, e, m:
  - NV when e==255.
  - NV when e>=158, except the single exact case s=1, e=158, m=0 (−2^31), which gives flags 0.
  - Otherwise NX when the operand is non-integral:
    - e<127 and the operand is nonzero, including denormals.
    - 127<=e<150 and any of the low (150−e) mantissa bits are nonzero.
  - e>=150 without NV is exact.
  - NV suppresses NX.
- FPU_CVTSW:
  - a = |in_operand|, where |0x80000000| is taken as 2^31.
  - p = MSB index of a.
  - NX when p>23 and any of a[p−24:0] is nonzero.
  - Zero input gives flags 0.
- Any other `in_op`: flags 0. Data and tag pass through unchanged.
- `in_result` is never modified. The stage trusts the convert unit's rounding and saturation.
- Sticky update: `fflags_next` = (`fflags_clr` ? 0 : `fflags`) | (pop ? `out_flags` : 0).
  - A clear in the same cycle as a pop keeps the popped flags.
  - Nothing is accumulated at push.

## Timing

- Reset values:
  - `out_valid`=0, `count`=0, `fflags`=0.
  - `out_data`, `out_rd` and `out_flags` are 0.
  - Read/write pointers are 0.
  - `in_ready`=0 while `rst` is high.
- `in_ready` = !rst && (`count` != DEPTH).
  - It is a function of registered state only, so there is no combinational path from `out_ready`.
  - When the FIFO is full, a same-cycle pop does not enable a push.
- Latency: a push at edge N into an empty FIFO gives `out_valid`=1 and valid head fields in cycle N+1. There is no bypass.
- Head fields are held stable while `out_valid && !out_ready`.
- Simultaneous push and pop with 0<`count`<DEPTH: `count` is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all entries immediately. Outputs take their reset values asynchronously.
- `fflags` changes only on clock edges.

## Test plan

- CVTWS accuracy: push `in_operand`=0x3FC00000 (1.5), `in_result`=1, `in_rd`=3 → next cycle `out_data`=1, `out_rd`=3, `out_flags`=0x01. After a pop, `fflags`=0x01.
- CVTWS saturation: push 0x4F000000 → `out_flags`=0x10. Push 0xCF000000 → `out_flags`=0x00. Push 0x7FC00000 (NaN) → `out_flags`=0x10. Push 0x3F000000 (0.5) → `out_flags`=0x01.
- CVTSW inexact: push 0x01000001 with `in_result`=0x4B800000 → `out_flags`=0x01. Push 0x01000000 → `out_flags`=0x00. Push 0x80000000 → `out_flags`=0x00.
- Backpressure (DEPTH=2): hold `out_ready`=0 and push tags 1, 2 → `count`=2 and `in_ready`=0; a third `in_valid` is ignored. Then set `out_ready`=1 → tags retire 1, 2 in consecutive cycles, and `in_ready` returns to 1 the cycle after the first pop.
- Sticky clear: with `fflags`=0x10, assert `fflags_clr` in the same cycle as a pop whose `out_flags`=0x01 → `fflags`=0x01. Assert `fflags_clr` alone → `fflags`=0x00.
- Reset mid-stream: with 2 entries queued, assert `rst` between clock edges → `out_valid`, `count`, `fflags` and `in_ready` are 0 immediately. After release, the first push appears with a one-cycle latency.
